// File: rtl/orange_chk_pkg.sv
// Shared types and helpers for the Orange response checker.
package orange_chk_pkg;

    localparam int N_IN_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } chk_state_e;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/orange_chk_cmp.sv
// One-stage registered compare of an observed output bit
// against the expected truth table entry for its vector index.
module orange_chk_cmp
    import orange_chk_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter logic [vec_count(N_IN)-1:0] EXPECTED = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [N_IN-1:0] idx_i,
    input  logic            y_i,
    output logic            valid_o,
    output logic            mm_o,
    output logic [N_IN-1:0] idx_o
);

    logic            valid_q, valid_d;
    logic            mm_q, mm_d;
    logic [N_IN-1:0] idx_q, idx_d;

    always_comb begin
        valid_d = valid_i;
        idx_d   = valid_i ? idx_i : idx_q;
        mm_d    = valid_i ? (y_i != EXPECTED[idx_i]) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mm_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mm_q    <= mm_d;
            idx_q   <= idx_d;
        end
    end

    assign valid_o = valid_q;
    assign mm_o    = mm_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/orange_resp_checker.sv
// Response checker: sequences a run over all 2^N_IN vectors,
// accumulates mismatch statistics and reports pass/fail.
module orange_resp_checker
    import orange_chk_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter logic [vec_count(N_IN)-1:0] EXPECTED = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       vec_valid,
    input  logic [N_IN-1:0]            vec_idx,
    input  logic                       dut_y,
    output logic                       vec_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N_IN:0]              mismatch_cnt,
    output logic                       first_fail_vld,
    output logic [N_IN-1:0]            first_fail_idx,
    output logic                       seq_err,
    output logic [vec_count(N_IN)-1:0] fail_map
);

    localparam int VEC_CNT = vec_count(N_IN);
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(VEC_CNT - 1);
    localparam logic [N_IN:0] CNT_MAX  = (N_IN+1)'(VEC_CNT);

    chk_state_e           state_q, state_d;
    logic [N_IN:0]        exp_idx_q, exp_idx_d;
    logic [N_IN:0]        mismatch_cnt_q, mismatch_cnt_d;
    logic [VEC_CNT-1:0]   fail_map_q, fail_map_d;
    logic                 first_fail_vld_q, first_fail_vld_d;
    logic [N_IN-1:0]      first_fail_idx_q, first_fail_idx_d;
    logic                 seq_err_q, seq_err_d;
    logic                 vec_ready_q, vec_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic                 accept;
    logic                 cmp_valid;
    logic                 cmp_mm;
    logic [N_IN-1:0]      cmp_idx;

    assign accept = vec_valid && vec_ready_q;

    orange_chk_cmp #(
        .N_IN     (N_IN),
        .EXPECTED (EXPECTED)
    ) u_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .idx_i   (vec_idx),
        .y_i     (dut_y),
        .valid_o (cmp_valid),
        .mm_o    (cmp_mm),
        .idx_o   (cmp_idx)
    );

    always_comb begin
        state_d          = state_q;
        exp_idx_d        = exp_idx_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        fail_map_d       = fail_map_q;
        first_fail_vld_d = first_fail_vld_q;
        first_fail_idx_d = first_fail_idx_q;
        seq_err_d        = seq_err_q;
        done_d           = done_q;
        pass_d           = pass_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d          = ST_RUN;
                    exp_idx_d        = '0;
                    mismatch_cnt_d   = '0;
                    fail_map_d       = '0;
                    first_fail_vld_d = 1'b0;
                    first_fail_idx_d = '0;
                    seq_err_d        = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    exp_idx_d = exp_idx_q + 1'b1;
                    if ({1'b0, vec_idx} != exp_idx_q) begin
                        seq_err_d = 1'b1;
                    end
                    if (exp_idx_q == LAST_IDX) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The compare stage only carries beats accepted in RUN, so it
        // drains exactly during RUN and the single FLUSH cycle.
        if (cmp_valid && cmp_mm) begin
            if (mismatch_cnt_q != CNT_MAX) begin
                mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            end
            fail_map_d[cmp_idx] = 1'b1;
            if (!first_fail_vld_q) begin
                first_fail_vld_d = 1'b1;
                first_fail_idx_d = cmp_idx;
            end
        end

        if (state_q == ST_FLUSH) begin
            done_d = 1'b1;
            pass_d = (mismatch_cnt_d == '0) && !seq_err_d;
        end

        vec_ready_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            exp_idx_q        <= '0;
            mismatch_cnt_q   <= '0;
            fail_map_q       <= '0;
            first_fail_vld_q <= 1'b0;
            first_fail_idx_q <= '0;
            seq_err_q        <= 1'b0;
            vec_ready_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            exp_idx_q        <= exp_idx_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            fail_map_q       <= fail_map_d;
            first_fail_vld_q <= first_fail_vld_d;
            first_fail_idx_q <= first_fail_idx_d;
            seq_err_q        <= seq_err_d;
            vec_ready_q      <= vec_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign vec_ready      = vec_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_fail_vld = first_fail_vld_q;
    assign first_fail_idx = first_fail_idx_q;
    assign seq_err        = seq_err_q;
    assign fail_map       = fail_map_q;

endmodule

// File: tb/tb_orange_resp_checker.sv
// Directed self-checking bench for orange_resp_checker
// with a 5-input truth table of 32'hA5A5_0F0F.
module tb_orange_resp_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        vec_valid;
    logic [4:0]  vec_idx;
    logic        dut_y;
    logic        vec_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  mismatch_cnt;
    logic        first_fail_vld;
    logic [4:0]  first_fail_idx;
    logic        seq_err;
    logic [31:0] fail_map;

    logic [31:0] exp_tab;
    int          checks;
    int          errors;

    orange_resp_checker #(
        .N_IN     (5),
        .EXPECTED (32'hA5A5_0F0F)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .vec_valid      (vec_valid),
        .vec_idx        (vec_idx),
        .dut_y          (dut_y),
        .vec_ready      (vec_ready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx),
        .seq_err        (seq_err),
        .fail_map       (fail_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one run: start, then beats until done or a cycle budget.
    // edges counts rising edges from the start edge (inclusive).
    task automatic run(input logic [31:0] flip, input bit gap,
                       input bit swap, input bit mid_start,
                       output int edges, output int accepts);
        int  i;
        bit  acc;
        bit  tog;
        i = 0;
        edges = 0;
        accepts = 0;
        tog = 1'b1;
        @(negedge clk);
        start = 1'b1;
        vec_valid = 1'b0;
        @(posedge clk);
        edges = 1;
        #1;
        start = 1'b0;
        while (!done && edges < 200) begin
            vec_valid = (i < 32) && (!gap || tog);
            if (swap && i == 5) vec_idx = 5'd6;
            else if (swap && i == 6) vec_idx = 5'd5;
            else vec_idx = 5'(i);
            dut_y = exp_tab[vec_idx] ^ flip[vec_idx];
            start = mid_start && (i == 5);
            acc = vec_valid && vec_ready;
            @(posedge clk);
            edges++;
            #1;
            if (acc) begin
                i++;
                accepts++;
            end
            tog = !tog;
        end
        vec_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({vec_ready, busy, done, pass} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {vec_ready, busy, done, pass});
        end
        checks++;
        if ({mismatch_cnt, first_fail_vld, first_fail_idx, seq_err} !== '0) begin
            errors++;
            $display("FAIL reset_stats: got %0h expected 0",
                     {mismatch_cnt, first_fail_vld, first_fail_idx, seq_err});
        end
        checks++;
        if (fail_map !== 32'h0) begin
            errors++;
            $display("FAIL reset_fail_map: got %h expected 0", fail_map);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_pass();
        int e, a;
        run(32'h0, 1'b0, 1'b0, 1'b0, e, a);
        checks++;
        if (e !== 34) begin
            errors++;
            $display("FAIL pass_latency: got %0d expected 34", e);
        end
        checks++;
        if ({done, pass, busy, vec_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL pass_flags: got %b expected 1100",
                     {done, pass, busy, vec_ready});
        end
        checks++;
        if (mismatch_cnt !== 6'd0 || fail_map !== 32'h0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL pass_stats: got cnt=%0d map=%h seq=%b expected 0/0/0",
                     mismatch_cnt, fail_map, seq_err);
        end
    endtask

    task automatic test_two_fail();
        int e, a;
        run(32'h0002_0008, 1'b0, 1'b0, 1'b0, e, a);
        checks++;
        if (mismatch_cnt !== 6'd2) begin
            errors++;
            $display("FAIL two_fail_cnt: got %0d expected 2", mismatch_cnt);
        end
        checks++;
        if (fail_map !== 32'h0002_0008) begin
            errors++;
            $display("FAIL two_fail_map: got %h expected 00020008", fail_map);
        end
        checks++;
        if (first_fail_vld !== 1'b1 || first_fail_idx !== 5'd3) begin
            errors++;
            $display("FAIL two_fail_first: got vld=%b idx=%0d expected 1/3",
                     first_fail_vld, first_fail_idx);
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL two_fail_flags: got done=%b pass=%b seq=%b expected 1/0/0",
                     done, pass, seq_err);
        end
    endtask

    task automatic test_rerun_clears();
        int e, a;
        run(32'h0, 1'b0, 1'b0, 1'b0, e, a);
        checks++;
        if (pass !== 1'b1 || mismatch_cnt !== 6'd0 || fail_map !== 32'h0
            || first_fail_vld !== 1'b0 || e !== 34) begin
            errors++;
            $display("FAIL rerun_clear: got pass=%b cnt=%0d map=%h ffv=%b edges=%0d expected 1/0/0/0/34",
                     pass, mismatch_cnt, fail_map, first_fail_vld, e);
        end
    endtask

    task automatic test_gapped();
        int e, a;
        run(32'h0, 1'b1, 1'b0, 1'b0, e, a);
        checks++;
        if (a !== 32 || e !== 65) begin
            errors++;
            $display("FAIL gapped_timing: got accepts=%0d edges=%0d expected 32/65",
                     a, e);
        end
        checks++;
        if (pass !== 1'b1 || mismatch_cnt !== 6'd0 || fail_map !== 32'h0
            || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL gapped_result: got pass=%b cnt=%0d map=%h seq=%b expected 1/0/0/0",
                     pass, mismatch_cnt, fail_map, seq_err);
        end
    endtask

    task automatic test_seq_swap();
        int e, a;
        run(32'h0, 1'b0, 1'b1, 1'b0, e, a);
        checks++;
        if (seq_err !== 1'b1 || mismatch_cnt !== 6'd0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL swap_result: got seq=%b cnt=%0d pass=%b expected 1/0/0",
                     seq_err, mismatch_cnt, pass);
        end
        checks++;
        if (done !== 1'b1 || e !== 34) begin
            errors++;
            $display("FAIL swap_done: got done=%b edges=%0d expected 1/34", done, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int e, a;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vec_valid = 1'b1;
            vec_idx = 5'(i);
            dut_y = exp_tab[i] ^ ((i == 2 || i == 7) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        vec_valid = 1'b0;
        checks++;
        if (mismatch_cnt !== 6'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_before_reset: got cnt=%0d busy=%b expected 2/1",
                     mismatch_cnt, busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_ready, busy, done, pass, first_fail_vld, seq_err} !== 6'b0
            || mismatch_cnt !== 6'd0 || fail_map !== 32'h0 || first_fail_idx !== 5'd0) begin
            errors++;
            $display("FAIL midrun_reset_clear: got flags=%b cnt=%0d map=%h ffi=%0d expected 0",
                     {vec_ready, busy, done, pass, first_fail_vld, seq_err},
                     mismatch_cnt, fail_map, first_fail_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(32'h0, 1'b0, 1'b0, 1'b0, e, a);
        checks++;
        if (pass !== 1'b1 || mismatch_cnt !== 6'd0 || e !== 34) begin
            errors++;
            $display("FAIL midrun_rerun: got pass=%b cnt=%0d edges=%0d expected 1/0/34",
                     pass, mismatch_cnt, e);
        end
    endtask

    task automatic test_ignored_inputs();
        int e, a;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec_valid = 1'b1;
            vec_idx = 5'(i);
            dut_y = ~exp_tab[i];
            @(negedge clk);
        end
        vec_valid = 1'b0;
        checks++;
        if ({vec_ready, busy, done} !== 3'b0 || mismatch_cnt !== 6'd0
            || fail_map !== 32'h0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got flags=%b cnt=%0d map=%h seq=%b expected 0",
                     {vec_ready, busy, done}, mismatch_cnt, fail_map, seq_err);
        end
        run(32'h0, 1'b0, 1'b0, 1'b1, e, a);
        checks++;
        if (e !== 34 || pass !== 1'b1 || mismatch_cnt !== 6'd0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_start_ignored: got edges=%0d pass=%b cnt=%0d seq=%b expected 34/1/0/0",
                     e, pass, mismatch_cnt, seq_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_valid = 1'b1;
            vec_idx = 5'(i + 8);
            dut_y = ~exp_tab[i + 8];
        end
        @(negedge clk);
        vec_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || mismatch_cnt !== 6'd0
            || fail_map !== 32'h0 || vec_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ignore: got done=%b pass=%b cnt=%0d map=%h rdy=%b expected 1/1/0/0/0",
                     done, pass, mismatch_cnt, fail_map, vec_ready);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_tab   = 32'hA5A5_0F0F;
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_valid = 1'b0;
        vec_idx   = '0;
        dut_y     = 1'b0;
        test_reset();
        test_all_pass();
        test_two_fail();
        test_rerun_clears();
        test_gapped();
        test_seq_swap();
        test_reset_mid_run();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/orange_resp_checker.md
Name: orange_resp_checker

Overview:
- Synthesizable response checker for the Orange combinational blocks. It sits at the receiving end of the exhaustive stimulus sequence.
- Accepts one input-vector index plus the DUT output bit per handshake.
- Compares each bit against a parameterized expected truth table.
- Accumulates mismatch statistics and reports pass/fail once all 2^N_IN vectors have been seen.

Parameters:
N_IN, 5, number of DUT inputs; vector count is 2^N_IN (32 by default)
EXPECTED, 32'h0000_0000, truth table; bit i is the expected Y for input vector i (width 2^N_IN)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new check run; sampled only in IDLE or DONE
vec_valid  input  1  stimulus side presents vec_idx/dut_y this cycle
vec_idx  input  N_IN  index of applied input vector ({A,B,C,D,E}, A = MSB)
dut_y  input  1  DUT output observed for vec_idx
vec_ready  output  1  checker can accept a vector
busy  output  1  run in progress
done  output  1  run complete; held until next start or reset
pass  output  1  valid when done: 1 iff mismatch_cnt==0 and seq_err==0
mismatch_cnt  output  N_IN+1  number of mismatching vectors (0..32)
first_fail_vld  output  1  at least one mismatch captured
first_fail_idx  output  N_IN  vec_idx of the first mismatch
seq_err  output  1  a vector arrived out of ascending order
fail_map  output  2^N_IN  bit i set if vector i mismatched

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including vec_ready, done, pass, counters, fail_map.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start -> RUN.
  - On entry: exp_idx=0; mismatch_cnt, fail_map, first_fail_*, seq_err, done and pass cleared.
  - The start cycle itself accepts no vector.
- RUN: vec_ready=1, busy=1. Accept when vec_valid && vec_ready.
  - Accepted beat is registered; comparison result is applied 1 cycle later (pipeline stage).
  - Mismatch when dut_y != EXPECTED[vec_idx]: mismatch_cnt+1, fail_map[vec_idx]=1.
  - If first_fail_vld==0 on a mismatch: capture first_fail_idx, set first_fail_vld.
  - If vec_idx != exp_idx: seq_err=1 (sticky). Comparison still uses vec_idx; exp_idx increments per accepted beat regardless.
  - On the accepted beat with exp_idx == 2^N_IN-1 -> FLUSH. vec_ready drops the next cycle.
- FLUSH: vec_ready=0; last registered comparison is applied -> DONE.
- DONE: busy=0, done=1, pass computed from final counts. Results stay stable until start or reset.
- Arithmetic:
  - exp_idx is N_IN+1 bits; no wrap occurs within a run.
  - mismatch_cnt saturates at 2^N_IN; it cannot exceed that in a legal run.
- vec_valid outside RUN is ignored, with no side effects.
- start while in RUN or FLUSH is ignored.
- Reset mid-run aborts immediately to IDLE, with all results cleared.
- Duplicate vec_idx within a run:
  - each beat is compared and counted;
  - fail_map bit is an OR of all beats for that index;
  - seq_err is set.
- Throughput: 1 vector/cycle. Total run = 2^N_IN accept cycles + 1 FLUSH + DONE.

Decomposition:
- Package orange_chk_pkg:
  - state enum type (IDLE, RUN, FLUSH, DONE);
  - localparam default N_IN=5;
  - function vec_count(n) = 2^n.
- Sub-module orange_chk_cmp: one-stage registered compare.
  - Inputs: vec_idx, dut_y, valid, EXPECTED.
  - Outputs: registered mismatch bit, index, valid.
  - Keeps the FSM/counter logic in the top.

Test Plan:
- EXPECTED=32'hA5A5_0F0F; start, then 32 in-order beats with dut_y=EXPECTED[i] back-to-back -> done on cycle 34 after start; pass=1, mismatch_cnt=0, fail_map=0, seq_err=0.
- Same table, dut_y inverted at indices 3 and 17 -> mismatch_cnt=2, fail_map=32'h0002_0008, first_fail_idx=3, pass=0.
- Beats with vec_valid toggled 1/0 every cycle, all correct -> identical results to the first case; done after 32 accepts + FLUSH; no beat lost.
- Indices 0..31 with 5 and 6 swapped, all dut_y correct -> seq_err=1, mismatch_cnt=0, pass=0.
- rst_n pulsed low after 10 beats with 2 mismatches -> all outputs 0 immediately. A new start plus 32 correct beats -> pass=1, mismatch_cnt=0.
- start asserted mid-RUN and vec_valid asserted in IDLE -> no state change, counters unaffected. A second start from DONE clears results and reruns correctly.
